// File: rtl/alu_bcd_pkg.sv
// Shared types and constants for the ALU result to BCD converter.
// Seven-segment constants are active-low gfedcba; they are used only when
// ALU_BCD_SEG7_EN is defined.
package alu_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;

    // Active-low segment pattern for a decimal digit; non-decimal codes blank.
    function automatic logic [6:0] seg7_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD digit to an active-low seven-segment pattern, with forced blanking.
module bcd_to_seg7
    import alu_bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg_c
);

    // Pure lookup; the parent registers the result.
    always_comb begin
        seg_c = SEG_BLANK;
        if (!blank) begin
            seg_c = seg7_digit(digit);
        end
    end

endmodule

// File: rtl/alu_result_bcd.sv
// Captures one ALU result plus overflow flag, converts the magnitude to packed
// BCD with sequential double-dabble and holds it behind a valid/ready handshake.
// Optional seven-segment outputs are enabled with the ALU_BCD_SEG7_EN macro.
module alu_result_bcd
    import alu_bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5,
    parameter int unsigned SIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      result,
    input  logic                  overflow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  err
`ifdef ALU_BCD_SEG7_EN
    ,
    output logic [7*DIGITS-1:0]   seg,
    output logic [6:0]            seg_sign
`endif
);

    localparam int unsigned BW        = 4 * DIGITS;
    localparam int unsigned CW        = $clog2(WIDTH + 1);
    localparam bit          IS_SIGNED = (SIGNED != 0);

    state_t            state;
    logic [WIDTH-1:0]  mag;
    logic [BW-1:0]     scratch;
    logic [CW-1:0]     cnt;

    logic [BW-1:0]     adj_c;
    logic [BW-1:0]     shift_c;
    logic [WIDTH-1:0]  mag_shift_c;
    logic              accept_c;
    logic              last_c;
    logic              is_neg_c;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next magnitude bit.
    always_comb begin
        adj_c = scratch;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        shift_c     = {adj_c[BW-2:0], mag[WIDTH-1]};
        mag_shift_c = {mag[WIDTH-2:0], 1'b0};
        accept_c    = in_valid & in_ready;
        last_c      = (cnt == CW'(WIDTH - 1));
        is_neg_c    = IS_SIGNED & result[WIDTH-1];
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bcd       <= '0;
            neg       <= 1'b0;
            err       <= 1'b0;
            mag       <= '0;
            scratch   <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        in_ready <= 1'b0;
                        if (overflow) begin
                            err       <= 1'b1;
                            bcd       <= '0;
                            neg       <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            // Two's complement negate is exact for the most negative value.
                            mag     <= is_neg_c ? (~result + WIDTH'(1)) : result;
                            neg     <= is_neg_c;
                            err     <= 1'b0;
                            scratch <= '0;
                            cnt     <= '0;
                            state   <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    scratch <= shift_c;
                    mag     <= mag_shift_c;
                    cnt     <= cnt + CW'(1);
                    if (last_c) begin
                        bcd       <= shift_c;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_BCD_SEG7_EN
    logic [DIGITS-1:0]   blank_c;
    logic [7*DIGITS-1:0] seg_c;
    logic                lead_zero_c;

    // Leading-zero blanking from the most significant digit down; ones digit always shown.
    always_comb begin
        blank_c     = '0;
        lead_zero_c = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            lead_zero_c = lead_zero_c & (shift_c[4*i +: 4] == 4'd0);
            blank_c[i]  = lead_zero_c & (i != 0);
        end
    end

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dig
        bcd_to_seg7 u_dig (
            .digit (shift_c[4*g +: 4]),
            .blank (blank_c[g]),
            .seg_c (seg_c[7*g +: 7])
        );
    end

    // Display registers load on the same edge that raises out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg      <= {DIGITS{SEG_BLANK}};
            seg_sign <= SEG_BLANK;
        end else if ((state == ST_IDLE) && accept_c && overflow) begin
            seg      <= {{(DIGITS-1){SEG_BLANK}}, SEG_E};
            seg_sign <= SEG_BLANK;
        end else if ((state == ST_SHIFT) && last_c) begin
            seg      <= seg_c;
            seg_sign <= neg ? SEG_MINUS : SEG_BLANK;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_bcd.sv
// Bench for alu_result_bcd: a signed and an unsigned instance share stimulus and
// are checked against a decimal-arithmetic model of the expected display value.
module tb_alu_result_bcd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        overflow = 1'b0;
    logic [15:0] result = '0;

    logic        s_in_ready, s_out_valid, s_neg, s_err;
    logic        u_in_ready, u_out_valid, u_neg, u_err;
    logic [19:0] s_bcd, u_bcd;
`ifdef ALU_BCD_SEG7_EN
    logic [34:0] s_seg, u_seg;
    logic [6:0]  s_seg_sign, u_seg_sign;
`endif

    int errors = 0;
    int checks = 0;

    int   exp_s_mag = 0;
    int   exp_u_mag = 0;
    logic exp_s_neg = 1'b0;
    logic exp_err   = 1'b0;

    always #5 clk = ~clk;

    alu_result_bcd #(.WIDTH(16), .DIGITS(5), .SIGNED(1)) u_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .result(result), .overflow(overflow), .out_valid(s_out_valid),
        .out_ready(out_ready), .bcd(s_bcd), .neg(s_neg), .err(s_err)
`ifdef ALU_BCD_SEG7_EN
        , .seg(s_seg), .seg_sign(s_seg_sign)
`endif
    );

    alu_result_bcd #(.WIDTH(16), .DIGITS(5), .SIGNED(0)) u_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(u_in_ready),
        .result(result), .overflow(overflow), .out_valid(u_out_valid),
        .out_ready(out_ready), .bcd(u_bcd), .neg(u_neg), .err(u_err)
`ifdef ALU_BCD_SEG7_EN
        , .seg(u_seg), .seg_sign(u_seg_sign)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal digits of a non-negative integer, ones digit in the low nibble.
    function automatic logic [19:0] to_bcd(input int m);
        logic [19:0] r;
        int v;
        r = '0;
        v = m;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

`ifdef ALU_BCD_SEG7_EN
    // {seg_sign, seg} the display should show for a magnitude/sign/error.
    function automatic logic [41:0] seg_model(input int m, input logic n, input logic e);
        logic [6:0]  tbl [10];
        logic [34:0] s;
        logic [6:0]  sg;
        int v;
        int p;
        tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        v = m;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            if (e) s[7*k +: 7] = (k == 0) ? 7'b0000110 : 7'h7F;
            else if (k > 0 && m < p) s[7*k +: 7] = 7'h7F;
            else s[7*k +: 7] = tbl[v % 10];
            v = v / 10;
            p = p * 10;
        end
        sg = (!e && n) ? 7'b0111111 : 7'h7F;
        return {sg, s};
    endfunction
`endif

    // Every cycle a finished value is presented, it must match the model.
    always @(negedge clk) begin
        if (rst_n && s_out_valid) begin
            chk("s_bcd", 64'(s_bcd), 64'(exp_err ? 20'h0 : to_bcd(exp_s_mag)));
            chk("s_neg", 64'(s_neg), 64'(exp_s_neg));
            chk("s_err", 64'(s_err), 64'(exp_err));
`ifdef ALU_BCD_SEG7_EN
            chk("s_seg", 64'({s_seg_sign, s_seg}), 64'(seg_model(exp_s_mag, exp_s_neg, exp_err)));
`endif
        end
        if (rst_n && u_out_valid) begin
            chk("u_bcd", 64'(u_bcd), 64'(exp_err ? 20'h0 : to_bcd(exp_u_mag)));
            chk("u_neg", 64'(u_neg), 64'(1'b0));
            chk("u_err", 64'(u_err), 64'(exp_err));
`ifdef ALU_BCD_SEG7_EN
            chk("u_seg", 64'({u_seg_sign, u_seg}), 64'(seg_model(exp_u_mag, 1'b0, exp_err)));
`endif
        end
    end

    // Offer one result, check latency, optionally stall the consumer, then drain.
    task automatic do_txn(input logic [15:0] r, input logic ovf, input int hold);
        int n;
        int k;
        int sv;
        n = 0;
        while (!(s_in_ready && u_in_ready) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 64'(s_in_ready), 64'(1'b1));
        sv        = int'($signed(r));
        exp_err   = ovf;
        exp_s_neg = !ovf && (sv < 0);
        exp_s_mag = ovf ? 0 : ((sv < 0) ? -sv : sv);
        exp_u_mag = ovf ? 0 : int'(r);
        in_valid  = 1'b1;
        result    = r;
        overflow  = ovf;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        overflow = 1'b0;
        result   = 16'($urandom);
        chk("accept_in_ready", 64'(s_in_ready), 64'(1'b0));
        k = 0;
        while (!s_out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 64'(k), 64'(ovf ? 0 : 16));
        chk("u_out_valid", 64'(u_out_valid), 64'(1'b1));
        repeat (hold) begin
            in_valid = 1'b1;
            result   = 16'($urandom);
            overflow = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_out_valid", 64'(s_out_valid), 64'(1'b1));
            chk("hold_in_ready", 64'(s_in_ready), 64'(1'b0));
        end
        in_valid  = 1'b0;
        overflow  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_out_valid", 64'(s_out_valid), 64'(1'b0));
        chk("drain_in_ready", 64'(s_in_ready), 64'(1'b1));
        chk("drain_u_in_ready", 64'(u_in_ready), 64'(1'b1));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(s_in_ready), 64'(1'b1));
        chk("rst_out_valid", 64'(s_out_valid), 64'(1'b0));
        chk("rst_bcd", 64'(s_bcd), 64'(20'h0));
        chk("rst_neg_err", 64'({s_neg, s_err}), 64'(2'b00));
`ifdef ALU_BCD_SEG7_EN
        chk("rst_seg", 64'({s_seg_sign, s_seg}), 64'({6{7'h7F}}));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_txn(16'd12345, 1'b0, 0);
        chk("lit_12345", 64'(s_bcd), 64'(20'h12345));
        chk("lit_12345_neg", 64'(s_neg), 64'(1'b0));
        do_txn(16'hFFFE, 1'b0, 2);
        chk("lit_fffe_s", 64'({s_neg, s_bcd}), 64'({1'b1, 20'h00002}));
        chk("lit_fffe_u", 64'(u_bcd), 64'(20'h65534));
        do_txn(16'h8000, 1'b0, 0);
        chk("lit_8000_s", 64'({s_neg, s_bcd}), 64'({1'b1, 20'h32768}));
        chk("lit_8000_u", 64'({u_neg, u_bcd}), 64'({1'b0, 20'h32768}));
        do_txn(16'hFFFF, 1'b0, 0);
        chk("lit_ffff_u", 64'({u_neg, u_bcd}), 64'({1'b0, 20'h65535}));
        do_txn(16'h0000, 1'b0, 0);
        chk("lit_zero_u", 64'(u_bcd), 64'(20'h0));
`ifdef ALU_BCD_SEG7_EN
        chk("lit_zero_seg", 64'({s_seg_sign, s_seg}), 64'({{5{7'h7F}}, 7'b1000000}));
`endif
        do_txn(16'h1234, 1'b1, 5);
        chk("lit_ovf", 64'({s_err, s_bcd}), 64'({1'b1, 20'h0}));
        do_txn(16'd999, 1'b0, 0);

        // Reset during the seventh shift cycle of a negative conversion.
        exp_s_neg = 1'b1;
        in_valid  = 1'b1;
        result    = 16'hFFF0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(s_out_valid), 64'(1'b0));
        chk("midrst_bcd", 64'(s_bcd), 64'(20'h0));
        chk("midrst_neg_err", 64'({s_neg, s_err}), 64'(2'b00));
        chk("midrst_in_ready", 64'(s_in_ready), 64'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            chk("postrst_no_valid", 64'(s_out_valid), 64'(1'b0));
        end

        for (int t = 0; t < 150; t++) begin
            do_txn(16'($urandom), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
